// File: rtl/gray_win_pkg.sv
// gray_win_pkg
//   Shared definitions for the gray-image window generator:
//   - default image geometry and address width
//   - controller state encoding
//   - byte index of each pixel inside the 72-bit 3x3 window
//     (index = row*3 + col, row 0 is the top row, WIN_C is the centre)
package gray_win_pkg;

  localparam int DEF_IMG_W  = 128;
  localparam int DEF_IMG_H  = 128;
  localparam int DEF_ADDR_W = 14;

  // Controller states. The encoding is fixed so that a bound checker or a
  // waveform viewer can decode the raw 2-bit value of the state register.
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FETCH = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } gray_win_state_e;

  // Window byte positions
  localparam int WIN_TL = 0;
  localparam int WIN_TC = 1;
  localparam int WIN_TR = 2;
  localparam int WIN_ML = 3;
  localparam int WIN_C  = 4;
  localparam int WIN_MR = 5;
  localparam int WIN_BL = 6;
  localparam int WIN_BC = 7;
  localparam int WIN_BR = 8;

endpackage

// File: rtl/gray_line_buf.sv
// gray_line_buf
//   Two line buffers of IMG_W 8-bit pixels. lb1 holds the previous image
//   row, lb2 the row before that. The column selected by col is read
//   combinationally; on wr_en the same column is shifted down one row
//   (lb2 <= lb1, lb1 <= wr_data) in a single cycle.
//
// Ports
//   clk      clock
//   col      column index being read / written
//   wr_en    shift-write enable (pixel accepted this cycle)
//   wr_data  incoming pixel for this column
//   rd_data  {lb2[col], lb1[col]} = {top pixel, middle pixel}
//
// The arrays are not reset: their contents are only ever read for rows
// that have already been written during the current frame.
module gray_line_buf
  import gray_win_pkg::*;
#(
  parameter int IMG_W = DEF_IMG_W,
  parameter int COL_W = $clog2(DEF_IMG_W)
) (
  input  logic             clk,
  input  logic [COL_W-1:0] col,
  input  logic             wr_en,
  input  logic [7:0]       wr_data,
  output logic [15:0]      rd_data
);

  logic [7:0] lb1 [IMG_W];
  logic [7:0] lb2 [IMG_W];

  assign rd_data = {lb2[col], lb1[col]};

  always_ff @(posedge clk) begin
    if (wr_en) begin
      lb2[col] <= lb1[col];
      lb1[col] <= wr_data;
    end
  end

endmodule

// File: rtl/gray_win_gen.sv
// gray_win_gen
//   Fetches an IMG_H x IMG_W 8-bit gray image in raster order from a
//   combinational gray memory and emits one 3x3 neighbourhood window per
//   interior pixel, together with the centre pixel address.
//
// Ports
//   clk, reset   clock, asynchronous active-high reset
//   start        one-cycle pulse, starts a frame when idle
//   gray_addr    address being fetched
//   gray_req     fetch request
//   gray_ready   gray_data is valid for gray_addr this cycle
//   gray_data    pixel value
//   win_valid    window valid
//   win_ready    consumer accepts window
//   win_data     window, byte k = win_data[8k+7:8k], k = row*3+col
//   win_addr     centre pixel address of the window
//   frame_done   one-cycle pulse after the last window is accepted
//   busy         high from start until frame_done
//   stall_cnt    (only with GRAY_WIN_STALL_CNT_EN) saturating count of
//                fetch cycles blocked by output backpressure
//
// Handshakes (both ports): a transfer happens on every cycle where the
// producer's valid/req and the consumer's ready are both high. While
// win_valid is high and win_ready is low, win_data/win_addr are held and
// no pixel is fetched. gray_req and gray_addr stay put while gray_ready
// is low.
//
// Build option: define GRAY_WIN_STALL_CNT_EN to add the stall_cnt port.
module gray_win_gen
  import gray_win_pkg::*;
#(
  parameter int IMG_W  = DEF_IMG_W,
  parameter int IMG_H  = DEF_IMG_H,
  parameter int ADDR_W = DEF_ADDR_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  output logic [ADDR_W-1:0] gray_addr,
  output logic              gray_req,
  input  logic              gray_ready,
  input  logic [7:0]        gray_data,
  output logic              win_valid,
  input  logic              win_ready,
  output logic [71:0]       win_data,
  output logic [ADDR_W-1:0] win_addr,
  output logic              frame_done,
  output logic              busy
`ifdef GRAY_WIN_STALL_CNT_EN
  ,
  output logic [15:0]       stall_cnt
`endif
);

  localparam int COL_W = $clog2(IMG_W);
  localparam int ROW_W = $clog2(IMG_H);

  localparam logic [COL_W-1:0]  LAST_COL  = COL_W'(IMG_W - 1);
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(IMG_W * IMG_H - 1);
  // Offset from the newest fetched pixel (bottom-right of the window) back
  // to the window centre: one row and one column.
  localparam logic [ADDR_W-1:0] CTR_OFF   = ADDR_W'(IMG_W + 1);

  gray_win_state_e  state;
  logic [COL_W-1:0] col;
  logic [ROW_W-1:0] row;
  logic [8:0][7:0]  win_q;
  logic [15:0]      lb_rd;
  logic             accept;
  logic             new_win;

  // Fetch only when the output slot is empty or is being emptied now.
  assign gray_req   = (state == ST_FETCH) && (!win_valid || win_ready);
  assign accept     = gray_req && gray_ready;
  assign new_win    = (row >= ROW_W'(2)) && (col >= COL_W'(2));
  assign busy       = (state == ST_FETCH) || (state == ST_DRAIN);
  assign frame_done = (state == ST_DONE);
  assign win_data   = win_q;

  gray_line_buf #(
    .IMG_W (IMG_W),
    .COL_W (COL_W)
  ) u_line_buf (
    .clk     (clk),
    .col     (col),
    .wr_en   (accept),
    .wr_data (gray_data),
    .rd_data (lb_rd)
  );

  // Controller and raster counters
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= ST_IDLE;
      gray_addr <= '0;
      row       <= '0;
      col       <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (start) begin
            state     <= ST_FETCH;
            gray_addr <= '0;
            row       <= '0;
            col       <= '0;
          end
        end
        ST_FETCH: begin
          if (accept) begin
            if (gray_addr == LAST_ADDR) begin
              // Address holds at the last pixel; only the final window
              // remains to be delivered.
              state <= ST_DRAIN;
            end else begin
              gray_addr <= gray_addr + ADDR_W'(1);
              if (col == LAST_COL) begin
                col <= '0;
                row <= row + ROW_W'(1);
              end else begin
                col <= col + COL_W'(1);
              end
            end
          end
        end
        ST_DRAIN: begin
          if (!win_valid || win_ready) begin
            state <= ST_DONE;
          end
        end
        ST_DONE: begin
          state <= ST_IDLE;
        end
        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

  // Window shift register and output slot. The shift happens only on a
  // pixel accept, which in turn only happens when the slot is free, so a
  // stalled window is never disturbed.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      win_q     <= '0;
      win_valid <= 1'b0;
      win_addr  <= '0;
    end else begin
      if (state == ST_IDLE && start) begin
        win_valid <= 1'b0;
      end else if (accept) begin
        win_q[WIN_TL] <= win_q[WIN_TC];
        win_q[WIN_TC] <= win_q[WIN_TR];
        win_q[WIN_TR] <= lb_rd[15:8];
        win_q[WIN_ML] <= win_q[WIN_C];
        win_q[WIN_C]  <= win_q[WIN_MR];
        win_q[WIN_MR] <= lb_rd[7:0];
        win_q[WIN_BL] <= win_q[WIN_BC];
        win_q[WIN_BC] <= win_q[WIN_BR];
        win_q[WIN_BR] <= gray_data;
        win_valid     <= new_win;
        if (new_win) begin
          win_addr <= gray_addr - CTR_OFF;
        end
      end else if (win_ready) begin
        win_valid <= 1'b0;
      end
    end
  end

`ifdef GRAY_WIN_STALL_CNT_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      stall_cnt <= '0;
    end else if (state == ST_IDLE && start) begin
      stall_cnt <= '0;
    end else if (state == ST_FETCH && win_valid && !win_ready &&
                 stall_cnt != 16'hFFFF) begin
      stall_cnt <= stall_cnt + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_gray_win_gen.sv
// tb_gray_win_gen
//   Bench for gray_win_gen with a 128x128 ramp image (gray[a] = a[7:0]).
//   Every accepted pixel that completes a window pushes the expected
//   {centre address, window bytes} onto exp_q; every window transfer pops
//   and compares. Frames run: reset mid-frame at window 5000, a full frame
//   with output stalls and a stray start pulse, and a full frame with
//   random gray_ready.
`timescale 1ns/1ps
module tb_gray_win_gen;

  localparam int W     = 128;
  localparam int H     = 128;
  localparam int AW    = 14;
  localparam int N_WIN = (H - 2) * (W - 2);
  localparam logic [71:0] FIRST_DATA =
    {8'd2, 8'd1, 8'd0, 8'd130, 8'd129, 8'd128, 8'd2, 8'd1, 8'd0};

  logic          clk = 1'b0;
  logic          reset;
  logic          start;
  logic [AW-1:0] gray_addr;
  logic          gray_req;
  logic          gray_ready;
  logic [7:0]    gray_data;
  logic          win_valid;
  logic          win_ready;
  logic [71:0]   win_data;
  logic [AW-1:0] win_addr;
  logic          frame_done;
  logic          busy;
`ifdef GRAY_WIN_STALL_CNT_EN
  logic [15:0]   stall_cnt;
`endif

  gray_win_gen #(
    .IMG_W  (W),
    .IMG_H  (H),
    .ADDR_W (AW)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .start      (start),
    .gray_addr  (gray_addr),
    .gray_req   (gray_req),
    .gray_ready (gray_ready),
    .gray_data  (gray_data),
    .win_valid  (win_valid),
    .win_ready  (win_ready),
    .win_data   (win_data),
    .win_addr   (win_addr),
    .frame_done (frame_done),
    .busy       (busy)
`ifdef GRAY_WIN_STALL_CNT_EN
    ,
    .stall_cnt  (stall_cnt)
`endif
  );

  // ---------------- clock / memory model ----------------
  always #5 clk = ~clk;

  always_comb gray_data = gray_addr[7:0];

  // ---------------- bench state ----------------
  int n_pass = 0;
  int n_chk  = 0;
  int cyc    = 0;
  int mode;          // 0: stalls, 1: random gray_ready, 2: reset mid-frame
  int pix_idx;
  int win_cnt;
  int last_addr;
  int fd_cnt;
  int hold_left;
  int hold_tgt;
  int ti;
  int rel_cyc;
  logic start_req;
  logic lat_pend;
  logic [AW-1:0] lat_addr;
  logic prev_blocked, prev_wait, prev_busy;
  logic [AW-1:0] prev_win_addr, prev_gray_addr;
  logic [71:0]   prev_win_data;
  logic [AW+71:0] exp_q[$];

  int stall_at  [5] = '{300, 2000, 6000, 10000, 14000};
  int stall_len [5] = '{5, 8, 8, 8, 8};

  // ---------------- checking ----------------
  task automatic check(input string tag, input logic [71:0] got,
                       input logic [71:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
  endtask

  // Expected window completed by the pixel with raster index idx.
  function automatic logic [AW+71:0] exp_win(input int idx);
    int r, c, p;
    logic [71:0]   d;
    logic [AW-1:0] a;
    r = idx / W;
    c = idx % W;
    d = '0;
    for (int dr = 0; dr < 3; dr++) begin
      for (int dc = 0; dc < 3; dc++) begin
        p = (r - 2 + dr) * W + (c - 2 + dc);
        d[8*(dr*3+dc) +: 8] = p[7:0];
      end
    end
    a = AW'((r - 1) * W + (c - 1));
    return {a, d};
  endfunction

  // ---------------- driver + monitor, one cycle ----------------
  task automatic tick();
    logic [AW+71:0] e;
    @(negedge clk);
    cyc++;
    start     = start_req;
    start_req = 1'b0;
    gray_ready = (mode == 1) ? 1'($urandom_range(0, 1)) : 1'b1;
    if (mode == 0 && hold_left == 0 && ti < 5 && win_valid &&
        win_addr == AW'(stall_at[ti])) begin
      hold_left = stall_len[ti];
      hold_tgt  = stall_at[ti];
      ti++;
    end
    win_ready = (hold_left == 0);
    if (hold_left > 0) begin
      hold_left--;
      if (hold_left == 0 && hold_tgt == 300) rel_cyc = cyc;
    end
    #1;

    if (lat_pend) begin
      check("win_latency_valid", 72'(win_valid), 72'(1));
      check("win_latency_addr", 72'(win_addr), 72'(lat_addr));
    end
    lat_pend = 1'b0;

    if (win_valid && !win_ready) begin
      check("stall_gray_req", 72'(gray_req), 72'(0));
      if (prev_blocked) begin
        check("stall_win_addr", 72'(win_addr), 72'(prev_win_addr));
        check("stall_win_data", win_data, prev_win_data);
        check("stall_gray_addr", 72'(gray_addr), 72'(prev_gray_addr));
      end
    end

    if (prev_wait) begin
      check("wait_gray_req", 72'(gray_req), 72'(1));
      check("wait_gray_addr", 72'(gray_addr), 72'(prev_gray_addr));
    end

    if (gray_req && gray_ready) begin
      check("gray_addr_seq", 72'(gray_addr), 72'(pix_idx));
      if (pix_idx / W >= 2 && pix_idx % W >= 2) begin
        e = exp_win(pix_idx);
        exp_q.push_back(e);
        lat_pend = 1'b1;
        lat_addr = e[AW+71:72];
      end
      pix_idx++;
    end

    if (win_valid && win_ready) begin
      check("win_q_nonempty", 72'(exp_q.size() != 0), 72'(1));
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        check("win_addr", 72'(win_addr), 72'(e[AW+71:72]));
        check("win_data", win_data, e[71:0]);
      end
      win_cnt++;
      last_addr = int'(win_addr);
      if (win_cnt == 1) begin
        check("first_win_addr", 72'(win_addr), 72'(129));
        check("first_win_data", win_data, FIRST_DATA);
      end
      if (mode == 0 && win_addr == AW'(301))
        check("resume_delay", 72'(cyc - rel_cyc), 72'(2));
      if (mode == 0 && win_cnt == 8000) start_req = 1'b1;
    end

    if (frame_done) begin
      fd_cnt++;
      check("busy_at_done", 72'(busy), 72'(0));
      check("busy_before_done", 72'(prev_busy), 72'(1));
    end

    prev_blocked   = win_valid && !win_ready;
    prev_wait      = gray_req && !gray_ready;
    prev_busy      = busy;
    prev_win_addr  = win_addr;
    prev_win_data  = win_data;
    prev_gray_addr = gray_addr;
  endtask

  task automatic clear_model();
    exp_q.delete();
    pix_idx      = 0;
    win_cnt      = 0;
    last_addr    = 0;
    fd_cnt       = 0;
    hold_left    = 0;
    hold_tgt     = 0;
    ti           = 0;
    rel_cyc      = 0;
    lat_pend     = 1'b0;
    prev_blocked = 1'b0;
    prev_wait    = 1'b0;
    prev_busy    = 1'b0;
  endtask

  task automatic check_reset_outputs(input string pfx);
    check({pfx, "_gray_req"},   72'(gray_req),   72'(0));
    check({pfx, "_gray_addr"},  72'(gray_addr),  72'(0));
    check({pfx, "_win_valid"},  72'(win_valid),  72'(0));
    check({pfx, "_win_addr"},   72'(win_addr),   72'(0));
    check({pfx, "_win_data"},   win_data,        72'(0));
    check({pfx, "_frame_done"}, 72'(frame_done), 72'(0));
    check({pfx, "_busy"},       72'(busy),       72'(0));
  endtask

  task automatic run_frame(input int m, input int budget, input int exp_stall);
    int n;
    mode = m;
    clear_model();
    start_req = 1'b1;
    n = 0;
    while (!frame_done && n < budget) begin
      tick();
      n++;
      if (m == 2 && win_cnt == 5000) break;
    end
    if (m == 2) begin
      // Asynchronous reset between clock edges, mid-frame.
      check("pre_reset_busy", 72'(busy), 72'(1));
      reset = 1'b1;
      #1;
      check_reset_outputs("midrst");
      @(posedge clk);
      #1;
      reset = 1'b0;
      clear_model();
      for (int i = 0; i < 8; i++) begin
        tick();
        check("idle_after_reset_busy", 72'(busy), 72'(0));
        check("idle_after_reset_req", 72'(gray_req), 72'(0));
      end
    end else begin
      check("frame_done_seen", 72'(frame_done), 72'(1));
      check("win_count", 72'(win_cnt), 72'(N_WIN));
      check("last_win_addr", 72'(last_addr), 72'(16254));
      check("exp_q_empty", 72'(exp_q.size()), 72'(0));
`ifdef GRAY_WIN_STALL_CNT_EN
      check("stall_cnt", 72'(stall_cnt), 72'(exp_stall));
`else
      if (exp_stall < 0) $display("unused stall expectation");
`endif
      tick();
      check("frame_done_pulse", 72'(frame_done), 72'(0));
      check("frame_done_count", 72'(fd_cnt), 72'(1));
      check("busy_after_done", 72'(busy), 72'(0));
    end
  endtask

  // ---------------- main sequence ----------------
  initial begin
    reset      = 1'b1;
    start      = 1'b0;
    start_req  = 1'b0;
    gray_ready = 1'b0;
    win_ready  = 1'b0;
    mode       = 2;
    clear_model();
    repeat (3) @(negedge clk);
    #1;
    check_reset_outputs("rst");
    reset = 1'b0;
    repeat (2) tick();
    check("idle_busy", 72'(busy), 72'(0));

    run_frame(2, 8000, 0);     // reset at window 5000
    run_frame(0, 20000, 37);   // restart: stalls + stray start
    run_frame(1, 60000, 0);    // random gray_ready

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
